// File: rtl/mdu_pkg.sv
// Shared types and widths for the MDU issue/writeback controller.
package mdu_pkg;

  localparam int XLEN = 32;
  localparam int REGW = 5;

  typedef enum logic [2:0] {
    MUL    = 3'b000,
    MULH   = 3'b001,
    MULHSU = 3'b010,
    MULHU  = 3'b011,
    DIV    = 3'b100,
    DIVU   = 3'b101,
    REM    = 3'b110,
    REMU   = 3'b111
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_WB    = 2'd3
  } mdu_issue_state_e;

endpackage

// File: rtl/mdu_result_cache.sv
// Single-entry result cache: remembers the last completed op/operands and its result.
module mdu_result_cache #(
  parameter int XLEN     = mdu_pkg::XLEN,
  parameter int CACHE_EN = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [2:0]      lk_op_i,
  input  logic [XLEN-1:0] lk_rs1_i,
  input  logic [XLEN-1:0] lk_rs2_i,
  output logic            hit_o,
  output logic [XLEN-1:0] data_o,
  input  logic            wr_en_i,
  input  logic [2:0]      wr_op_i,
  input  logic [XLEN-1:0] wr_rs1_i,
  input  logic [XLEN-1:0] wr_rs2_i,
  input  logic [XLEN-1:0] wr_data_i
);
  import mdu_pkg::*;

  logic            valid_q, valid_d;
  mdu_op_e         op_q, op_d;
  logic [XLEN-1:0] rs1_q, rs1_d;
  logic [XLEN-1:0] rs2_q, rs2_d;
  logic [XLEN-1:0] data_q, data_d;

  // Next entry contents: overwrite on a completed MDU result.
  always_comb begin
    valid_d = valid_q;
    op_d    = op_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    data_d  = data_q;
    if (wr_en_i) begin
      valid_d = 1'b1;
      op_d    = mdu_op_e'(wr_op_i);
      rs1_d   = wr_rs1_i;
      rs2_d   = wr_rs2_i;
      data_d  = wr_data_i;
    end else begin
      valid_d = valid_q;
    end
  end

  // Entry storage, invalidated by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      op_q    <= MUL;
      rs1_q   <= '0;
      rs2_q   <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      op_q    <= op_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      data_q  <= data_d;
    end
  end

  // Full op and full-width operand compare so DIV/REM never alias.
  assign hit_o  = (CACHE_EN != 0) && valid_q && (op_q == mdu_op_e'(lk_op_i)) &&
                  (rs1_q == lk_rs1_i) && (rs2_q == lk_rs2_i);
  assign data_o = data_q;

endmodule

// File: rtl/mdu_issue.sv
// Issue/writeback controller between EX decode and a multi-cycle MDU,
// with a one-entry repeat-op result cache.
module mdu_issue #(
  parameter int XLEN     = mdu_pkg::XLEN,
  parameter int REGW     = mdu_pkg::REGW,
  parameter int CACHE_EN = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  input  logic [REGW-1:0] rd_addr_i,
  input  logic            flush_i,
  output logic            stall_o,
  output logic            mdu_valid_o,
  output logic [2:0]      mdu_op_o,
  output logic [XLEN-1:0] mdu_rs1_o,
  output logic [XLEN-1:0] mdu_rs2_o,
  input  logic            mdu_ready_i,
  input  logic [XLEN-1:0] mdu_rd_i,
  output logic            wb_valid_o,
  output logic [REGW-1:0] wb_rd_addr_o,
  output logic [XLEN-1:0] wb_data_o
);
  import mdu_pkg::*;

  mdu_issue_state_e state_q, state_d;
  mdu_op_e          op_q, op_d;
  logic [XLEN-1:0]  rs1_q, rs1_d;
  logic [XLEN-1:0]  rs2_q, rs2_d;
  logic [REGW-1:0]  rd_q, rd_d;
  logic [XLEN-1:0]  data_q, data_d;
  logic             kill_q, kill_d;
  logic             first_q, first_d;
  logic             ready_q, ready_d;

  logic             accept_s;
  logic             dead_s;
  logic             hit_s;
  logic             cache_wr_s;
  logic [XLEN-1:0]  cache_data_s;

  assign accept_s = ready_q && (state_q == ST_IDLE) && req_valid_i && !flush_i;
  assign dead_s   = (rd_addr_i == '0);

  mdu_result_cache #(
    .XLEN     (XLEN),
    .CACHE_EN (CACHE_EN)
  ) u_cache (
    .clk       (clk),
    .rst       (rst),
    .lk_op_i   (funct3_i),
    .lk_rs1_i  (rs1_data_i),
    .lk_rs2_i  (rs2_data_i),
    .hit_o     (hit_s),
    .data_o    (cache_data_s),
    .wr_en_i   (cache_wr_s),
    .wr_op_i   (op_q),
    .wr_rs1_i  (rs1_q),
    .wr_rs2_i  (rs2_q),
    .wr_data_i (mdu_rd_i)
  );

  // Next-state and holding-register update.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    rs1_d      = rs1_q;
    rs2_d      = rs2_q;
    rd_d       = rd_q;
    data_d     = data_q;
    kill_d     = kill_q;
    first_d    = first_q;
    cache_wr_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        kill_d = 1'b0;
        if (accept_s) begin
          op_d  = mdu_op_e'(funct3_i);
          rs1_d = rs1_data_i;
          rs2_d = rs2_data_i;
          rd_d  = rd_addr_i;
          if (dead_s) begin
            state_d = ST_IDLE;
          end else if (hit_s) begin
            data_d  = cache_data_s;
            state_d = ST_WB;
          end else begin
            state_d = ST_ISSUE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        kill_d  = kill_q | flush_i;
        first_d = 1'b1;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        kill_d = kill_q | flush_i;
        // The MDU cannot be aborted; a killed op still completes and refreshes the cache.
        if (first_q) begin
          first_d = 1'b0;
        end else if (mdu_ready_i) begin
          data_d     = mdu_rd_i;
          cache_wr_s = 1'b1;
          if (kill_q || flush_i) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_WB;
          end
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_WB: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    ready_d = (state_d == ST_IDLE);
  end

  // State and holding registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= MUL;
      rs1_q   <= '0;
      rs2_q   <= '0;
      rd_q    <= '0;
      data_q  <= '0;
      kill_q  <= 1'b0;
      first_q <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      rd_q    <= rd_d;
      data_q  <= data_d;
      kill_q  <= kill_d;
      first_q <= first_d;
      ready_q <= ready_d;
    end
  end

  assign req_ready_o  = ready_q;
  assign stall_o      = (state_q != ST_IDLE) || (accept_s && !dead_s);
  assign mdu_valid_o  = (state_q == ST_ISSUE);
  assign mdu_op_o     = op_q;
  assign mdu_rs1_o    = rs1_q;
  assign mdu_rs2_o    = rs2_q;
  assign wb_valid_o   = (state_q == ST_WB) && !flush_i;
  assign wb_rd_addr_o = rd_q;
  assign wb_data_o    = data_q;

endmodule

// File: doc/mdu_issue.md
Name: mdu_issue

Overview:
- Issue/writeback controller between the EX-stage decoder and the multi-cycle MDU.
- Accepts one decoded RV32M instruction, sends a single-cycle valid pulse with operands to the MDU, and stalls the pipeline while the MDU computes.
- Captures the MDU result and emits one register-file writeback.
- Holds a one-entry result cache so that an identical back-to-back M-op completes without re-issue.

Parameters:
- XLEN, 32, operand/result width
- REGW, 5, register index width
- CACHE_EN, 1, 1 enables the repeat-op result cache; 0 always issues to the MDU

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- req_valid_i  in  1  decoded M-extension instruction present
- req_ready_o  out  1  request accepted this cycle (valid & ready)
- funct3_i  in  3  RV32M funct3, forwarded as MDU op code
- rs1_data_i  in  XLEN  operand A
- rs2_data_i  in  XLEN  operand B
- rd_addr_i  in  REGW  destination register
- flush_i  in  1  kill the current/in-flight instruction (branch mispredict or trap)
- stall_o  out  1  hold upstream pipeline
- mdu_valid_o  out  1  one-cycle issue pulse to the MDU
- mdu_op_o  out  3  MDU op
- mdu_rs1_o  out  XLEN  MDU operand A
- mdu_rs2_o  out  XLEN  MDU operand B
- mdu_ready_i  in  1  MDU result valid
- mdu_rd_i  in  XLEN  MDU result
- wb_valid_o  out  1  writeback strobe, one cycle
- wb_rd_addr_o  out  REGW  writeback register
- wb_data_o  out  XLEN  writeback data

Behaviour:
- Reset values:
  - All outputs 0.
  - req_ready_o is 0 during reset and 1 in IDLE thereafter.
  - State IDLE; cache invalid.
- States: IDLE, ISSUE, WAIT, WB.
- IDLE:
  - req_ready_o=1.
  - On req_valid_i & !flush_i, latch funct3, rs1, rs2 and rd into holding registers.
  - If rd==0: the op is architecturally dead. Go to IDLE, no issue, no wb, stall_o stays 0.
  - Else if cache hit (CACHE_EN, cache valid, op, rs1 and rs2 all equal): go to WB with the cached data. Total latency 1 cycle.
  - Else go to ISSUE.
- ISSUE:
  - mdu_valid_o=1 for exactly this cycle; mdu_op/rs1/rs2 come from the holding registers.
  - Operand outputs stay stable until WB exits.
  - Go to WAIT.
- WAIT:
  - MDU contract: mdu_ready_i is low from the cycle after the issue pulse until the result is valid.
  - mdu_ready_i is ignored during the first WAIT cycle and qualified from the second WAIT cycle on.
  - On a qualified mdu_ready_i: capture mdu_rd_i, update the cache (op, rs1, rs2, data, valid=1), go to WB.
- WB:
  - wb_valid_o=1 for one cycle with the latched rd and data.
  - Go to IDLE.
- stall_o:
  - 1 in ISSUE, WAIT and WB.
  - Also 1 in the IDLE cycle that accepts a non-dead request.
  - Upstream holds the instruction until the cycle after WB.
- Flush:
  - In ISSUE or WAIT: set a kill flag. The MDU cannot be aborted, so the block keeps waiting for mdu_ready_i.
  - On completion the cache is still updated (the result is correct for those operands), but WB is skipped and the state returns to IDLE with wb_valid_o=0.
  - In WB: suppress wb_valid_o.
  - In IDLE: the request is not accepted.
- Simultaneous flush_i and mdu_ready_i in WAIT: the flush wins, so no wb; the cache is updated.
- Reset mid-operation: the block returns to IDLE immediately and the cache is invalidated. The MDU is reset by the same rst.
- Cache hit compares all XLEN bits of both operands plus the full 3-bit op; DIV and REM are never merged.
- No width extension: results pass through unmodified.

Decomposition:
- Shared package mdu_pkg:
  - mdu_op_e: MUL=000, MULH=001, MULHSU=010, MULHU=011, DIV=100, DIVU=101, REM=110, REMU=111.
  - mdu_issue_state_e.
  - XLEN/REGW localparams.
- One natural sub-module: mdu_result_cache (single-entry tag+data register, compare, invalidate on rst).

Test Plan:
- MUL 10*20 to rd=5 → one mdu_valid_o pulse, stall_o high until WB, wb_valid_o with rd=5 and data 200; stall deasserted the cycle after WB.
- DIV 100/10 to rd=3, then the identical DIV again → second request has no mdu_valid_o, wb data 10 one cycle after acceptance; REM 100/10 after it → issued to the MDU, wb 0.
- REM 10%3 with flush_i asserted mid-WAIT → no wb_valid_o, returns to IDLE after mdu_ready_i; an identical REM next → cache hit, wb data 1.
- MUL 7*9 with rd=0 → no mdu_valid_o, no wb, stall_o never asserted.
- DIV 100/0 to rd=4 → MDU issued, wb data 0xFFFFFFFF; rst asserted during a later WAIT → all outputs 0 next cycle, cache invalid (a repeat DIV 100/0 re-issues).
- mdu_ready_i held high in the first WAIT cycle → ignored; the result is taken only on the later qualified ready.
